// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-port memory responder.
// Access sizes, FSM states and byte-lane mask helpers.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_access_size_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC_LO = 3'd1,
        ACC_HI = 3'd2,
        LAST   = 3'd3,
        RESP   = 3'd4
    } data_mem_state_t;

    // The unused fourth encoding falls into the default and behaves as a word.
    function automatic logic [3:0] size_to_mask(input mem_access_size_t size);
        case (size)
            SIZE_BYTE: size_to_mask = 4'b0001;
            SIZE_HALF: size_to_mask = 4'b0011;
            default:   size_to_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic access_spans(input mem_access_size_t size, input logic [1:0] off);
        logic [7:0] mask8;
        mask8 = {4'b0000, size_to_mask(size)} << off;
        access_spans = |mask8[7:4];
    endfunction

endpackage

// File: rtl/data_mem_responder_align.sv
// Byte-lane alignment between the right-aligned core view and the word-wide SRAM.
// Produces low/high word byte enables and write data, and the right-aligned load result.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]       off_i,
    input  mem_access_size_t size_i,
    input  logic [31:0]      wdata_i,
    input  logic [31:0]      lo_word_i,
    input  logic [31:0]      hi_word_i,
    output logic [3:0]       be_lo_o,
    output logic [3:0]       be_hi_o,
    output logic [31:0]      wdata_lo_o,
    output logic [31:0]      wdata_hi_o,
    output logic [31:0]      rdata_o
);

    logic [3:0]  mask;
    logic [7:0]  mask8;
    logic [63:0] wdata64;
    logic [63:0] rdata64;
    logic [31:0] keep;

    always_comb begin
        mask       = size_to_mask(size_i);
        mask8      = {4'b0000, mask} << off_i;
        wdata64    = {32'b0, wdata_i} << {off_i, 3'b000};
        rdata64    = {hi_word_i, lo_word_i} >> {off_i, 3'b000};
        keep       = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        be_lo_o    = mask8[3:0];
        be_hi_o    = mask8[7:4];
        wdata_lo_o = wdata64[31:0];
        wdata_hi_o = wdata64[63:32];
        rdata_o    = rdata64[31:0] & keep;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data port: one load/store per valid/ready transaction,
// split into two SRAM cycles when the access crosses a word boundary.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [31:0]           req_addr_i,
    input  mem_access_size_t      req_size_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  sram_en_o,
    output logic                  sram_we_o,
    output logic [3:0]            sram_be_o,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i,
    output data_mem_state_t       dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Requests are taken only in IDLE; a response is held with stable data until rsp_ready_i.

    data_mem_state_t    state_q, state_d;
    logic               we_q, we_d;
    logic [ADDR_W+1:0]  addr_q, addr_d;
    mem_access_size_t   size_q, size_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [ADDR_W-1:0]  word;
    logic [1:0]         off;
    logic               span;
    logic [3:0]         be_lo, be_hi;
    logic [31:0]        wdata_lo, wdata_hi, rdata_aligned, lo_word;
    logic               unused_addr_hi;

    assign unused_addr_hi = &{1'b0, req_addr_i[31:ADDR_W+2]};
    assign word           = addr_q[ADDR_W+1:2];
    assign off            = addr_q[1:0];
    assign span           = access_spans(size_q, off);
    // Unsplit loads finish in LAST with the only read word still on the bus.
    assign lo_word        = span ? lo_q : sram_rdata_i;

    mem_lane_align u_align (
        .off_i      (off),
        .size_i     (size_q),
        .wdata_i    (wdata_q),
        .lo_word_i  (lo_word),
        .hi_word_i  (sram_rdata_i),
        .be_lo_o    (be_lo),
        .be_hi_o    (be_hi),
        .wdata_lo_o (wdata_lo),
        .wdata_hi_o (wdata_hi),
        .rdata_o    (rdata_aligned)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        rdata_d      = rdata_q;
        req_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        sram_en_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_be_o    = 4'b0000;
        sram_addr_o  = '0;
        sram_wdata_o = 32'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i[ADDR_W+1:0];
                    size_d  = req_size_i;
                    wdata_d = req_wdata_i;
                    rdata_d = 32'b0;
                    state_d = ACC_LO;
                end
            end
            ACC_LO: begin
                sram_en_o    = 1'b1;
                sram_we_o    = we_q;
                sram_be_o    = be_lo;
                sram_addr_o  = word;
                sram_wdata_o = wdata_lo;
                state_d      = span ? ACC_HI : (we_q ? RESP : LAST);
            end
            ACC_HI: begin
                sram_en_o    = 1'b1;
                sram_we_o    = we_q;
                sram_be_o    = be_hi;
                sram_addr_o  = word + 1'b1;
                sram_wdata_o = wdata_hi;
                lo_d         = sram_rdata_i;
                state_d      = we_q ? RESP : LAST;
            end
            LAST: begin
                rdata_d = rdata_aligned;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= SIZE_WORD;
            wdata_q <= 32'b0;
            lo_q    <= 32'b0;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a behavioural SRAM and strobe monitor.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int ADDR_W = 14;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       wdata;
    } strobe_t;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic              req_we_i = 1'b0;
    logic [31:0]       req_addr_i = 32'b0;
    mem_access_size_t  req_size_i = SIZE_WORD;
    logic [31:0]       req_wdata_i = 32'b0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [31:0]       rsp_rdata_o;
    logic              sram_en_o;
    logic              sram_we_o;
    logic [3:0]        sram_be_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [31:0]       sram_wdata_o;
    logic [31:0]       sram_rdata = 32'b0;
    data_mem_state_t   dbg_state_o;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    strobe_t     obs_q[$];
    int          total = 0;
    int          bad = 0;

    // clock/reset
    always #5 clk_i = ~clk_i;

    data_mem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_size_i   (req_size_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .sram_en_o    (sram_en_o),
        .sram_we_o    (sram_we_o),
        .sram_be_o    (sram_be_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata),
        .dbg_state_o  (dbg_state_o)
    );

    // Behavioural SRAM plus a monitor logging every strobe.
    always @(posedge clk_i) begin
        if (sram_en_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] = sram_wdata_o[8*b +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_addr_o];
            end
            obs_q.push_back('{we: sram_we_o, addr: sram_addr_o, be: sram_be_o,
                              wdata: (sram_we_o ? sram_wdata_o : 32'b0)});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_strobe(input string tag, input int idx, input strobe_t exp);
        strobe_t got;
        got = (idx < obs_q.size()) ? obs_q[idx] : '0;
        check(tag, 64'(got), 64'(exp));
    endtask

    // Driver: one full transaction; hold = cycles rsp_ready_i stays low once the response is up.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata, input int hold,
                           output int lat, output logic [31:0] rdata);
        int n;
        obs_q.delete();
        @(negedge clk_i);
        check("ready_before_req", 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_size_i  = mem_access_size_t'(size);
        req_wdata_i = wdata;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        lat = 0;
        while (!rsp_valid_o && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        if (!rsp_valid_o) check("rsp_timeout", 64'(rsp_valid_o), 64'd1);
        rdata = rsp_rdata_o;
        n = obs_q.size();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            check("hold_valid", 64'(rsp_valid_o), 64'd1);
            check("hold_rdata", 64'(rsp_rdata_o), 64'(rdata));
            check("hold_ready", 64'(req_ready_o), 64'd0);
            check("hold_no_strobe", 64'(obs_q.size()), 64'(n));
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b0;
        @(negedge clk_i);
        check("idle_after_rsp", 64'(dbg_state_o), 64'(IDLE));
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;

        mem[14'h0040] = 32'hDEADBEEF;
        mem[14'h0080] = 32'hCAFE1234;
        mem[14'h0020] = 32'h01020304;
        mem[14'h0000] = 32'h00000000;
        mem[14'h3FFF] = 32'h00000000;

        #3;
        check("rst_state", 64'(dbg_state_o), 64'(IDLE));
        check("rst_ready", 64'(req_ready_o), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_sram_en", 64'(sram_en_o), 64'd0);
        check("rst_rdata", 64'(rsp_rdata_o), 64'd0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;

        // LW 0x100
        run_txn(1'b0, 32'h100, 2'd2, 32'h0, 0, lat, rd);
        check("lw_lat", 64'(lat), 64'd3);
        check("lw_rdata", 64'(rd), 64'hDEADBEEF);
        check("lw_nstrobe", 64'(obs_q.size()), 64'd1);
        check_strobe("lw_strobe", 0, '{we: 1'b0, addr: 14'h40, be: 4'hF, wdata: 32'h0});

        // SB 0x103
        run_txn(1'b1, 32'h103, 2'd0, 32'h000000A5, 0, lat, rd);
        check("sb_lat", 64'(lat), 64'd2);
        check("sb_rdata", 64'(rd), 64'd0);
        check("sb_nstrobe", 64'(obs_q.size()), 64'd1);
        check_strobe("sb_strobe", 0, '{we: 1'b1, addr: 14'h40, be: 4'b1000, wdata: 32'hA5000000});

        // Reading back the merged word confirms only lane 3 was written.
        run_txn(1'b0, 32'h100, 2'd2, 32'h0, 0, lat, rd);
        check("sb_readback", 64'(rd), 64'hA5ADBEEF);

        // Split LW 0x0FE
        mem[14'h003F] = 32'h11223344;
        mem[14'h0040] = 32'h55667788;
        run_txn(1'b0, 32'h0FE, 2'd2, 32'h0, 0, lat, rd);
        check("lw_split_lat", 64'(lat), 64'd4);
        check("lw_split_rdata", 64'(rd), 64'h77881122);
        check("lw_split_nstrobe", 64'(obs_q.size()), 64'd2);
        check_strobe("lw_split_lo", 0, '{we: 1'b0, addr: 14'h3F, be: 4'b1100, wdata: 32'h0});
        check_strobe("lw_split_hi", 1, '{we: 1'b0, addr: 14'h40, be: 4'b0011, wdata: 32'h0});

        // Split SH across the top word, wrapping to word 0
        run_txn(1'b1, 32'h0000FFFF, 2'd1, 32'h0000BEEF, 0, lat, rd);
        check("sh_wrap_lat", 64'(lat), 64'd3);
        check("sh_wrap_nstrobe", 64'(obs_q.size()), 64'd2);
        check_strobe("sh_wrap_lo", 0, '{we: 1'b1, addr: 14'h3FFF, be: 4'b1000, wdata: 32'hEF000000});
        check_strobe("sh_wrap_hi", 1, '{we: 1'b1, addr: 14'h0000, be: 4'b0001, wdata: 32'h000000BE});
        check("sh_wrap_mem_top", 64'(mem[14'h3FFF]), 64'hEF000000);
        check("sh_wrap_mem_0", 64'(mem[14'h0000]), 64'h000000BE);

        // LH 0x202 with a stalled response
        run_txn(1'b0, 32'h202, 2'd1, 32'h0, 5, lat, rd);
        check("lh_lat", 64'(lat), 64'd3);
        check("lh_rdata", 64'(rd), 64'h0000CAFE);
        check("lh_nstrobe", 64'(obs_q.size()), 64'd1);
        check_strobe("lh_strobe", 0, '{we: 1'b0, addr: 14'h80, be: 4'b1100, wdata: 32'h0});

        // LB 0x81 and the reserved size encoding (acts as a word)
        run_txn(1'b0, 32'h081, 2'd0, 32'h0, 0, lat, rd);
        check("lb_rdata", 64'(rd), 64'h00000003);
        run_txn(1'b0, 32'h080, 2'd3, 32'h0, 0, lat, rd);
        check("size3_rdata", 64'(rd), 64'h01020304);
        check_strobe("size3_strobe", 0, '{we: 1'b0, addr: 14'h20, be: 4'hF, wdata: 32'h0});

        // Reset in the middle of ACC_HI of a split store
        obs_q.delete();
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h203;
        req_size_i  = SIZE_HALF;
        req_wdata_i = 32'h00001234;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        check("mid_acc_lo", 64'(dbg_state_o), 64'(ACC_LO));
        @(negedge clk_i);
        check("mid_acc_hi", 64'(dbg_state_o), 64'(ACC_HI));
        reset_i = 1'b0;
        #1;
        check("mid_rst_state", 64'(dbg_state_o), 64'(IDLE));
        check("mid_rst_en", 64'(sram_en_o), 64'd0);
        check("mid_rst_we", 64'(sram_we_o), 64'd0);
        check("mid_rst_be", 64'(sram_be_o), 64'd0);
        check("mid_rst_addr", 64'(sram_addr_o), 64'd0);
        check("mid_rst_wdata", 64'(sram_wdata_o), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("mid_rst_ready", 64'(req_ready_o), 64'd1);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("mid_rst_nstrobe", 64'(obs_q.size()), 64'd1);
        check_strobe("mid_rst_lo", 0, '{we: 1'b1, addr: 14'h80, be: 4'b1000, wdata: 32'h34000000});
        check("mid_rst_no_rsp", 64'(rsp_valid_o), 64'd0);
        check("mid_rst_ready_after", 64'(req_ready_o), 64'd1);
        check("mid_rst_mem", 64'(mem[14'h0080]), 64'h34FE1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
